port_map_lookup: RTL and testbench
==================================

Name: port_map_lookup

Overview:
- Parametrised successor to the hardwired switch lookup; sits in the user data path between input arbiter and output queues.
- Rewrites the IOQ module header destination field from a per-source-port map.
- Adds source-exclusion mode and whole-packet drop when the resolved destination is empty.
- Adds saturating forwarded/dropped packet counters and a configurable-depth output buffer.

Parameters:
- DATA_WIDTH, 64, data bus width.
- CTRL_WIDTH, DATA_WIDTH/8, control bus width.
- NUM_OUTPUT_QUEUES, 8, port count; also map row width.
- IO_QUEUE_STAGE_NUM, `IO_QUEUE_STAGE_NUM, ctrl value marking the IOQ header word.
- FIFO_DEPTH_BITS, 2, log2 of output buffer depth (min 2).
- CNT_WIDTH, 32, counter width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_data  in  DATA_WIDTH  input word
- in_ctrl  in  CTRL_WIDTH  input ctrl
- in_wr  in  1  input word valid
- in_rdy  out  1  ready to accept input
- out_data  out  DATA_WIDTH  output word
- out_ctrl  out  CTRL_WIDTH  output ctrl
- out_wr  out  1  output word valid
- out_rdy  in  1  downstream ready
- port_map  in  NUM_OUTPUT_QUEUES*NUM_OUTPUT_QUEUES  row s = destination mask for source s
- excl_src  in  1  1: clear source bit from resolved mask
- cnt_clr  in  1  synchronous clear of both counters
- pkt_fwd_cnt  out  CNT_WIDTH  packets forwarded
- pkt_drop_cnt  out  CNT_WIDTH  packets dropped

Behaviour:
- Reset is asynchronous active-low; clk is the only clock.
- Reset values: out_wr=0, counters=0, state=HDRS, FIFO empty. in_rdy=1 after reset.
- in_rdy = !fifo_nearly_full; the upstream holds in_wr low when in_rdy=0.
- src = in_data[`IOQ_SRC_PORT_POS+15:`IOQ_SRC_PORT_POS] (16 bits).
- If src < NUM_OUTPUT_QUEUES: mask = port_map row src, ANDed with ~(1<<src) when excl_src=1.
- If src >= NUM_OUTPUT_QUEUES: mask = 0.
- port_map and excl_src are sampled only on the IOQ header word; changes mid-packet do not affect that packet.
- State machine, evaluated only when in_wr=1:
  - HDRS:
    - ctrl==IO_QUEUE_STAGE_NUM and mask!=0: write word with dst field [`IOQ_DST_PORT_POS +: NUM_OUTPUT_QUEUES] replaced by mask; fwd_cnt++; stay.
    - ctrl==IO_QUEUE_STAGE_NUM and mask==0: word not written; drop_cnt++; go to DROP_HDRS.
    - other nonzero ctrl: written unchanged.
    - ctrl==0: written; go to PKT.
  - PKT: every word written; ctrl!=0 (last word) returns to HDRS.
  - DROP_HDRS: no words written; ctrl==0 goes to DROP_PKT.
  - DROP_PKT: no words written; ctrl!=0 returns to HDRS.
- The IOQ header must be the first word of a packet; module headers preceding it in the same packet are forwarded regardless.
- Output: fifo_rd_en = out_rdy && !fifo_empty; out_wr is fifo_rd_en registered one cycle; out_data/out_ctrl are valid with out_wr.
  - Minimum latency: a word written at edge N gives out_wr=1 in the cycle after edge N+2.
  - Full throughput of 1 word/cycle while out_rdy=1.
- Counters:
  - Saturate at all-ones.
  - cnt_clr has priority over a same-cycle increment; the result is 0.
  - Forward and drop events are mutually exclusive per word.
- Reset mid-packet: FIFO contents discarded, state to HDRS; the next word is treated as the start of a packet.
- Drop with full FIFO: dropped words are still accepted while in_rdy=1; they never occupy FIFO space.

Test Plan:
- port_map row 2 = 8'h30, excl_src=0, 4-word packet from src 2 (IOQ hdr, 3 data words) -> output IOQ dst field = 8'h30, other bits unchanged; 4 out_wr pulses; pkt_fwd_cnt=1.
- excl_src=1, row 1 = 8'hFF, src 1 -> dst=8'hFD.
- excl_src=1, row 3 = 8'h08, src 3 -> packet fully dropped; no out_wr; pkt_drop_cnt=1; a following packet passes intact.
- src=9 with NUM_OUTPUT_QUEUES=8 -> dropped; drop_cnt increments.
- out_rdy=0 for 20 cycles during a 10-word stream with FIFO_DEPTH_BITS=2 -> in_rdy deasserts; no word lost or duplicated after out_rdy=1.
- Counter preset near saturation with CNT_WIDTH=4: 17 forwarded packets -> pkt_fwd_cnt=4'hF.
- cnt_clr coincident with a forward -> count=0.
- reset_n low for 1 cycle mid-packet -> out_wr=0 immediately; the next packet is processed from HDRS correctly.

Source files
------------

// File: rtl/port_map_lookup.sv
// Rewrites the IOQ header destination field from a per-source-port map, drops packets
// whose resolved destination is empty, counts forwarded/dropped packets, and buffers output.
`ifndef IO_QUEUE_STAGE_NUM
`define IO_QUEUE_STAGE_NUM 8'hff
`endif
`ifndef IOQ_DST_PORT_POS
`define IOQ_DST_PORT_POS 0
`endif
`ifndef IOQ_SRC_PORT_POS
`define IOQ_SRC_PORT_POS 16
`endif

module port_map_lookup #(
    parameter int DATA_WIDTH        = 64,
    parameter int CTRL_WIDTH        = DATA_WIDTH/8,
    parameter int NUM_OUTPUT_QUEUES = 8,
    parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM = `IO_QUEUE_STAGE_NUM,
    parameter int FIFO_DEPTH_BITS   = 2,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic [DATA_WIDTH-1:0]                        in_data,
    input  logic [CTRL_WIDTH-1:0]                        in_ctrl,
    input  logic                                         in_wr,
    output logic                                         in_rdy,
    output logic [DATA_WIDTH-1:0]                        out_data,
    output logic [CTRL_WIDTH-1:0]                        out_ctrl,
    output logic                                         out_wr,
    input  logic                                         out_rdy,
    input  logic [NUM_OUTPUT_QUEUES*NUM_OUTPUT_QUEUES-1:0] port_map,
    input  logic                                         excl_src,
    input  logic                                         cnt_clr,
    output logic [CNT_WIDTH-1:0]                         pkt_fwd_cnt,
    output logic [CNT_WIDTH-1:0]                         pkt_drop_cnt
);

    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;

    typedef enum logic [1:0] {HDRS, PKT, DROP_HDRS, DROP_PKT} state_t;
    state_t state, state_nxt;

    logic [15:0]                  src;
    logic [NUM_OUTPUT_QUEUES-1:0] mask;
    logic                         accept, is_hdr;
    logic                         wr_nxt, fwd_ev, drop_ev;
    logic [DATA_WIDTH-1:0]        data_nxt;

    logic                         stg_valid;
    logic [DATA_WIDTH-1:0]        stg_data;
    logic [CTRL_WIDTH-1:0]        stg_ctrl;

    logic [DATA_WIDTH-1:0]        mem_data [DEPTH];
    logic [CTRL_WIDTH-1:0]        mem_ctrl [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0]   wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_BITS:0]     count, occ;
    logic                         fifo_empty, fifo_rd_en, fifo_nearly_full;

    assign src    = in_data[`IOQ_SRC_PORT_POS +: 16];
    assign accept = in_wr && in_rdy;
    assign is_hdr = (in_ctrl == IO_QUEUE_STAGE_NUM);

    always_comb begin
        mask = '0;
        for (int unsigned s = 0; s < NUM_OUTPUT_QUEUES; s++) begin
            if (src == 16'(s)) begin
                mask = port_map[s*NUM_OUTPUT_QUEUES +: NUM_OUTPUT_QUEUES];
                if (excl_src) mask[s] = 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        wr_nxt    = 1'b0;
        fwd_ev    = 1'b0;
        drop_ev   = 1'b0;
        data_nxt  = in_data;
        if (accept) begin
            case (state)
                HDRS: begin
                    if (is_hdr) begin
                        if (mask != '0) begin
                            wr_nxt = 1'b1;
                            fwd_ev = 1'b1;
                            data_nxt[`IOQ_DST_PORT_POS +: NUM_OUTPUT_QUEUES] = mask;
                        end else begin
                            drop_ev   = 1'b1;
                            state_nxt = DROP_HDRS;
                        end
                    end else begin
                        wr_nxt = 1'b1;
                        if (in_ctrl == '0) state_nxt = PKT;
                    end
                end
                PKT: begin
                    wr_nxt = 1'b1;
                    if (in_ctrl != '0) state_nxt = HDRS;
                end
                DROP_HDRS: if (in_ctrl == '0) state_nxt = DROP_PKT;
                DROP_PKT:  if (in_ctrl != '0) state_nxt = HDRS;
                default:   state_nxt = HDRS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= HDRS;
        else          state <= state_nxt;
    end

    // The staged word counts toward occupancy so in_rdy stays a pure register decode.
    assign occ              = count + {{FIFO_DEPTH_BITS{1'b0}}, stg_valid};
    assign fifo_nearly_full = (occ >= (FIFO_DEPTH_BITS+1)'(DEPTH));
    assign in_rdy           = !fifo_nearly_full;
    assign fifo_empty       = (count == '0);
    assign fifo_rd_en       = out_rdy && !fifo_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stg_valid <= 1'b0;
            stg_data  <= '0;
            stg_ctrl  <= '0;
        end else begin
            stg_valid <= wr_nxt;
            stg_data  <= data_nxt;
            stg_ctrl  <= in_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (stg_valid) begin
            mem_data[wr_ptr] <= stg_data;
            mem_ctrl[wr_ptr] <= stg_ctrl;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_wr   <= 1'b0;
            out_data <= '0;
            out_ctrl <= '0;
        end else begin
            if (stg_valid)  wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd_en) rd_ptr <= rd_ptr + 1'b1;
            if (stg_valid && !fifo_rd_en)      count <= count + 1'b1;
            else if (!stg_valid && fifo_rd_en) count <= count - 1'b1;
            out_wr <= fifo_rd_en;
            if (fifo_rd_en) begin
                out_data <= mem_data[rd_ptr];
                out_ctrl <= mem_ctrl[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_fwd_cnt  <= '0;
            pkt_drop_cnt <= '0;
        end else if (cnt_clr) begin
            pkt_fwd_cnt  <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            if (fwd_ev && pkt_fwd_cnt != '1)   pkt_fwd_cnt  <= pkt_fwd_cnt + 1'b1;
            if (drop_ev && pkt_drop_cnt != '1) pkt_drop_cnt <= pkt_drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_port_map_lookup.sv
// Scoreboard bench for port_map_lookup: expected words queued at drive time, popped on out_wr.
module tb_port_map_lookup;

    localparam int DW   = 64;
    localparam int CW   = 8;
    localparam int NQ   = 8;
    localparam int CNTW = 4;
    localparam logic [CW-1:0] HDR = 8'hff;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [DW-1:0]   in_data = '0;
    logic [CW-1:0]   in_ctrl = '0;
    logic            in_wr = 1'b0;
    logic            in_rdy;
    logic [DW-1:0]   out_data;
    logic [CW-1:0]   out_ctrl;
    logic            out_wr;
    logic            out_rdy = 1'b1;
    logic [NQ*NQ-1:0] port_map;
    logic            excl_src = 1'b0;
    logic            cnt_clr = 1'b0;
    logic [CNTW-1:0] pkt_fwd_cnt, pkt_drop_cnt;

    logic [7:0] pmap [NQ];
    for (genvar g = 0; g < NQ; g++) begin : g_pm
        assign port_map[g*8 +: 8] = pmap[g];
    end

    port_map_lookup #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_OUTPUT_QUEUES(NQ),
        .IO_QUEUE_STAGE_NUM(HDR), .FIFO_DEPTH_BITS(2), .CNT_WIDTH(CNTW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .port_map(port_map), .excl_src(excl_src), .cnt_clr(cnt_clr),
        .pkt_fwd_cnt(pkt_fwd_cnt), .pkt_drop_cnt(pkt_drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [CW+DW-1:0] exp_q [$];
    logic [CW+DW-1:0] exp_w;
    logic [CNTW-1:0]  exp_fwd = '0;
    logic [CNTW-1:0]  exp_drop = '0;
    bit   mon_en = 1'b1;
    bit   saw_not_rdy = 1'b0;
    bit   lat_arm = 1'b0;
    int   out_cnt = 0;
    time  t_first = 0;
    time  t_hdr_ret = 0;

    always @(negedge clk) begin
        if (mon_en && reset_n && out_wr) begin
            out_cnt++;
            if (lat_arm) begin
                t_first = $time;
                lat_arm = 1'b0;
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_word: got ctrl=%h data=%h, required no output", out_ctrl, out_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({out_ctrl, out_data} !== exp_w) begin
                    errors++;
                    $display("FAIL out_word: got ctrl=%h data=%h, required ctrl=%h data=%h",
                             out_ctrl, out_data, exp_w[DW +: CW], exp_w[DW-1:0]);
                end
            end
        end
    end

    task automatic send_word(input logic [DW-1:0] d, input logic [CW-1:0] c);
        int unsigned guard = 0;
        while (!in_rdy && guard < 200) begin
            saw_not_rdy = 1'b1;
            in_wr = 1'b0;
            @(negedge clk);
            guard++;
        end
        if (!in_rdy) begin
            checks++;
            errors++;
            $display("FAIL in_rdy_timeout: got in_rdy=0 after %0d cycles, required 1", guard);
        end
        in_data = d;
        in_ctrl = c;
        in_wr   = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_pkt(input logic [15:0] src, input int nwords, input bit excl,
                            input bit clr, input bit push);
        logic [DW-1:0] hdr, hexp, w;
        logic [CW-1:0] c;
        logic [7:0]    mask;
        logic [2:0]    si;
        si  = src[2:0];
        hdr = {$urandom, $urandom};
        hdr[31:16] = src;
        mask = 8'h00;
        if (src < 16'(NQ)) begin
            mask = pmap[si];
            if (excl) mask[si] = 1'b0;
        end
        hexp = hdr;
        hexp[7:0] = mask;
        if (clr) begin
            exp_fwd  = '0;
            exp_drop = '0;
        end else if (mask != 8'h00) begin
            if (exp_fwd != 4'hf) exp_fwd++;
        end else begin
            if (exp_drop != 4'hf) exp_drop++;
        end
        if (push && mask != 8'h00) exp_q.push_back({HDR, hexp});
        excl_src = excl;
        cnt_clr  = clr;
        send_word(hdr, HDR);
        t_hdr_ret = $time;
        cnt_clr = 1'b0;
        for (int i = 1; i < nwords; i++) begin
            w = {$urandom, $urandom};
            c = (i == nwords-1) ? 8'h80 : 8'h00;
            if (push && mask != 8'h00) exp_q.push_back({c, w});
            send_word(w, c);
        end
        in_wr = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned guard = 0;
        out_rdy = 1'b1;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d words pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_cnts(input string name);
        checks += 2;
        if (pkt_fwd_cnt !== exp_fwd) begin
            errors++;
            $display("FAIL %s_fwd_cnt: got %0d, required %0d", name, pkt_fwd_cnt, exp_fwd);
        end
        if (pkt_drop_cnt !== exp_drop) begin
            errors++;
            $display("FAIL %s_drop_cnt: got %0d, required %0d", name, pkt_drop_cnt, exp_drop);
        end
    endtask

    task automatic check_outs(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s_out_count: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NQ; i++) pmap[i] = 8'h00;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks += 2;
        if (out_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_wr: got %b, required 0", out_wr);
        end
        if (in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_rdy: got %b, required 1", in_rdy);
        end
        check_cnts("reset");
    endtask

    task automatic test_forward();
        int base = out_cnt;
        pmap[2] = 8'h30;
        lat_arm = 1'b1;
        send_pkt(16'd2, 4, 1'b0, 1'b0, 1'b1);
        drain("forward");
        check_outs("forward", out_cnt - base, 4);
        checks++;
        if (t_first - t_hdr_ret != 20) begin
            errors++;
            $display("FAIL forward_latency: got %0t, required 20", t_first - t_hdr_ret);
        end
        check_cnts("forward");
    endtask

    task automatic test_excl();
        pmap[1] = 8'hff;
        send_pkt(16'd1, 3, 1'b1, 1'b0, 1'b1);
        drain("excl");
        check_cnts("excl");
    endtask

    task automatic test_drop();
        int base = out_cnt;
        pmap[3] = 8'h08;
        send_pkt(16'd3, 5, 1'b1, 1'b0, 1'b1);
        drain("drop");
        check_outs("drop", out_cnt - base, 0);
        send_pkt(16'd2, 3, 1'b0, 1'b0, 1'b1);
        drain("after_drop");
        check_outs("after_drop", out_cnt - base, 3);
        check_cnts("drop");
    endtask

    task automatic test_bad_src();
        send_pkt(16'd9, 3, 1'b0, 1'b0, 1'b1);
        send_pkt(16'h0102, 3, 1'b0, 1'b0, 1'b1);
        drain("bad_src");
        check_cnts("bad_src");
    endtask

    task automatic test_drop_full();
        out_rdy = 1'b0;
        saw_not_rdy = 1'b0;
        send_pkt(16'd9, 8, 1'b0, 1'b0, 1'b1);
        checks++;
        if (saw_not_rdy) begin
            errors++;
            $display("FAIL drop_full_in_rdy: got in_rdy=0 during drop, required 1");
        end
        drain("drop_full");
        check_cnts("drop_full");
    endtask

    task automatic test_back_to_back();
        int base = out_cnt;
        saw_not_rdy = 1'b0;
        out_rdy = 1'b0;
        fork
            begin
                repeat (20) @(negedge clk);
                out_rdy = 1'b1;
            end
            send_pkt(16'd2, 10, 1'b0, 1'b0, 1'b1);
        join
        drain("backpressure");
        checks++;
        if (!saw_not_rdy) begin
            errors++;
            $display("FAIL backpressure_in_rdy: got in_rdy always 1, required deassert");
        end
        check_outs("backpressure", out_cnt - base, 10);
        check_cnts("backpressure");
    endtask

    task automatic test_cnt_clr();
        send_pkt(16'd2, 3, 1'b0, 1'b1, 1'b1);
        drain("cnt_clr");
        check_cnts("cnt_clr");
    endtask

    task automatic test_saturate();
        pmap[4] = 8'h01;
        for (int p = 0; p < 17; p++) begin
            send_pkt(16'd4, 3, 1'b0, 1'b0, 1'b1);
            if (p == 14) check_cnts("sat15");
        end
        drain("saturate");
        check_cnts("saturate");
    endtask

    task automatic test_reset_mid();
        int unsigned guard = 0;
        logic [DW-1:0] w;
        mon_en = 1'b0;
        out_rdy = 1'b1;
        w = {$urandom, $urandom};
        w[31:16] = 16'd2;
        send_word(w, HDR);
        send_word({$urandom, $urandom}, 8'h00);
        in_wr = 1'b0;
        while (!out_wr && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!out_wr) begin
            errors++;
            $display("FAIL reset_mid_pre_out_wr: got 0, required 1");
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_out_wr: got %b, required 0", out_wr);
        end
        exp_fwd  = '0;
        exp_drop = '0;
        check_cnts("reset_mid");
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        @(negedge clk);
        send_pkt(16'd2, 4, 1'b0, 1'b0, 1'b1);
        drain("reset_mid_next");
        check_cnts("reset_mid_next");
    endtask

    initial begin
        test_reset();
        test_forward();
        test_excl();
        test_drop();
        test_bad_src();
        test_drop_full();
        test_back_to_back();
        test_cnt_clr();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
